graph_mem_arbiter: RTL and testbench
====================================

// Module: graph_mem_arbiter
// PURPOSE
//  Shares one fixed-latency BRAM read port among NUM_REQ request streams, e.g. the
//  two {tag,addr} request ports of the graph fetch unit or several fetch units.
//  Round-robin grant, one request per cycle. Each read returns {tag,data} to the
//  issuing requester via an in-flight ID pipeline. A drain controller quiesces the
//  port for reconfiguration or a frontier switch.
// PARAMETERS
//  NUM_REQ      2   number of requesters (>=2); ID width RW=$clog2(NUM_REQ)
//  ADDR_W       32  address width
//  TAG_W        4   opaque tag width, echoed with the response
//  DATA_W       32  memory read data width
//  MEM_LATENCY  2   cycles from mem_en_out to valid mem_rdata_in (>=1)
// PORTS
//  clk_in         in   1                    clock
//  rst_in         in   1                    async reset, active high
//  req_valid_in   in   [NUM_REQ]            request valid per requester
//  req_in         in   [NUM_REQ][TAG_W+ADDR_W] request {tag,addr} per requester
//  req_ready_out  out  [NUM_REQ]            request accepted this cycle (comb)
//  mem_en_out     out  1                    BRAM read enable (registered)
//  mem_addr_out   out  ADDR_W               BRAM read address (registered)
//  mem_rdata_in   in   DATA_W               BRAM read data
//  rsp_valid_out  out  [NUM_REQ]            response valid, one-hot (registered)
//  rsp_out        out  TAG_W+DATA_W         response {tag,data}, shared by all
//  drain_in       in   1                    level: stop granting, empty pipeline
//  drained_out    out  1                    no grants and nothing in flight
//  idle_out       out  1                    no valid entry in the ID pipeline
// BEHAVIOUR
//  Reset (async): ptr=0, state=RUN, ID pipeline cleared.
//   Outputs after reset: mem_en_out=0, mem_addr_out=0, rsp_valid_out=0,
//   rsp_out=0, drained_out=0, idle_out=1.
//  Arbitration (state RUN only):
//   - Winner: first i with req_valid_in[i], scanning ptr, ptr+1, ... mod NUM_REQ.
//   - req_ready_out[winner]=1 and all other bits 0. All bits 0 if no valid request
//     or if state is not RUN.
//   - req_ready_out never depends on req_in contents.
//   - On a grant: ptr <= (winner+1) mod NUM_REQ. With no grant, ptr holds.
//  Issue: request accepted at cycle T -> mem_en_out=1, mem_addr_out=addr at T+1.
//   - A pipeline entry {valid,id,tag} enters at T+1.
//   - With no grant, mem_en_out=0 and mem_addr_out holds its last value.
//  Return: entry shifts MEM_LATENCY stages; mem_rdata_in is sampled at T+1+MEM_LATENCY.
//   - At T+2+MEM_LATENCY: rsp_valid_out[id]=1, rsp_out={tag,mem_rdata_in}.
//   - Total latency from accept to response: MEM_LATENCY+2 cycles.
//   - Throughput: 1 request/cycle. No response backpressure: consumers must sink
//     the response.
//   - rsp_out holds its value when rsp_valid_out=0.
//  Ordering: responses return in grant order. Per-requester order is preserved.
//  Drain FSM:
//   - RUN -> DRAIN when drain_in=1. The grant in that same cycle is suppressed.
//   - DRAIN -> DRAINED when pipeline empty and no response pending on the outputs.
//   - DRAINED -> RUN when drain_in=0. drained_out=1 only in DRAINED.
//   - DRAIN -> RUN if drain_in drops before DRAINED is reached; pipeline contents
//     are unaffected.
//  Boundaries:
//   - All requesters valid every cycle: strict rotation 0,1,..,NUM_REQ-1,0.
//   - Single requester valid: it is granted every cycle.
//   - Reset mid-flight: in-flight reads are discarded. mem_rdata_in arriving after
//     reset produces no response.
//   - Pipeline depth is exactly MEM_LATENCY+1. No overflow is possible.
// TESTING
//  1. Reset, req0 valid {tag=3,addr=0x10}, BRAM[0x10]=6 -> mem_en_out at T+1, addr 0x10;
//     rsp_valid_out=01 and rsp_out={3,6} at T+4 (MEM_LATENCY=2).
//  2. Both requesters valid continuously, 8 cycles -> grants alternate 0,1,0,1...;
//     8 responses, ids alternate, each tag matches its request.
//  3. Only req1 valid, 4 back-to-back requests -> req_ready_out=10 each cycle;
//     4 consecutive responses to requester 1 in order.
//  4. Assert drain_in with 3 reads in flight -> no new grants; drained_out rises the
//     cycle after the last response; drop drain_in -> grants resume next cycle.
//  5. Assert rst_in mid-stream with 2 reads in flight -> outputs at reset values
//     immediately (asynchronously); no rsp_valid_out pulses after release; idle_out=1.
//  6. MEM_LATENCY=1, NUM_REQ=3, all valid -> rotation 0,1,2,0; latency 3 cycles.

Source files
------------

// File: rtl/graph_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : graph_mem_arbiter
// Purpose  : Round-robin sharing of one fixed-latency BRAM read port among
//            NUM_REQ {tag,addr} request streams. Responses are routed back to
//            the issuer through an in-flight ID pipeline. A drain controller
//            quiesces the port for reconfiguration or a frontier switch.
// Revision : 1.0 - initial release
// ============================================================================
module graph_mem_arbiter #(
   parameter int NUM_REQ     = 2,
   parameter int ADDR_W      = 32,
   parameter int TAG_W       = 4,
   parameter int DATA_W      = 32,
   parameter int MEM_LATENCY = 2
) (
   input  logic                              clk_in,
   input  logic                              rst_in,
   input  logic [NUM_REQ-1:0]                req_valid_in,
   input  logic [NUM_REQ*(TAG_W+ADDR_W)-1:0] req_in,
   output logic [NUM_REQ-1:0]                req_ready_out,
   output logic                              mem_en_out,
   output logic [ADDR_W-1:0]                 mem_addr_out,
   input  logic [DATA_W-1:0]                 mem_rdata_in,
   output logic [NUM_REQ-1:0]                rsp_valid_out,
   output logic [TAG_W+DATA_W-1:0]           rsp_out,
   input  logic                              drain_in,
   output logic                              drained_out,
   output logic                              idle_out
);

   // Requester i occupies req_in[i*c_req_w +: c_req_w] as {tag, addr}
   localparam int c_rw    = $clog2(NUM_REQ);
   localparam int c_req_w = TAG_W + ADDR_W;
   localparam int c_depth = MEM_LATENCY + 1;

   typedef enum logic [1:0] {
      S_RUN     = 2'd0,
      S_DRAIN   = 2'd1,
      S_DRAINED = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic                 w_grant_en;
   logic [c_rw-1:0]      r_ptr;
   logic                 w_any_vld;
   logic                 w_hi_vld;
   logic [c_rw-1:0]      w_lo;
   logic [c_rw-1:0]      w_hi;
   logic [c_rw-1:0]      w_winner;
   logic                 w_grant;
   logic [c_req_w-1:0]   w_req_sel;
   logic                 w_pipe_empty;

   logic                 r_mem_en;
   logic [ADDR_W-1:0]    r_mem_addr;
   logic [c_depth-1:0]   r_pipe_vld;
   logic [c_rw-1:0]      r_pipe_id  [c_depth];
   logic [TAG_W-1:0]     r_pipe_tag [c_depth];
   logic [NUM_REQ-1:0]   r_rsp_vld;
   logic [TAG_W+DATA_W-1:0] r_rsp_data;

   assign w_pipe_empty = ~|r_pipe_vld;

   // Round-robin pick: lowest valid index >= ptr, else lowest valid index overall
   always_comb begin
      w_any_vld = 1'b0;
      w_hi_vld  = 1'b0;
      w_lo      = '0;
      w_hi      = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req_valid_in[i]) begin
            w_any_vld = 1'b1;
            w_lo      = c_rw'(i);
         end
         if (req_valid_in[i] && (c_rw'(i) >= r_ptr)) begin
            w_hi_vld = 1'b1;
            w_hi     = c_rw'(i);
         end
      end
      w_winner = w_hi_vld ? w_hi : w_lo;
   end

   assign w_grant   = w_any_vld & w_grant_en;
   assign w_req_sel = req_in[w_winner*c_req_w +: c_req_w];

   // One-hot ready to the winner; depends only on valids and FSM state
   always_comb begin
      req_ready_out = '0;
      if (w_grant) begin
         req_ready_out[w_winner] = 1'b1;
      end
   end

   // Drain FSM next state; grants are only allowed in RUN with drain_in low
   always_comb begin
      w_state_nxt = r_state;
      w_grant_en  = 1'b0;
      case (r_state)
         S_RUN: begin
            if (drain_in) w_state_nxt = S_DRAIN;
            else          w_grant_en  = 1'b1;
         end
         S_DRAIN: begin
            // An empty pipeline means the last response (if any) leaves the
            // output register at this edge, so DRAINED starts fully quiet.
            if (!drain_in)         w_state_nxt = S_RUN;
            else if (w_pipe_empty) w_state_nxt = S_DRAINED;
         end
         S_DRAINED: begin
            if (!drain_in) w_state_nxt = S_RUN;
         end
         default: w_state_nxt = S_RUN;
      endcase
   end

   // State register and round-robin pointer
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_state <= S_RUN;
         r_ptr   <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_grant) begin
            r_ptr <= (w_winner == c_rw'(NUM_REQ - 1)) ? '0 : w_winner + c_rw'(1);
         end
      end
   end

   // Issue register: address holds its last value when nothing is granted
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_mem_en   <= 1'b0;
         r_mem_addr <= '0;
      end else begin
         r_mem_en <= w_grant;
         if (w_grant) begin
            r_mem_addr <= w_req_sel[ADDR_W-1:0];
         end
      end
   end

   // In-flight ID pipeline, aligned so the last stage meets mem_rdata_in
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_pipe_vld <= '0;
         for (int k = 0; k < c_depth; k++) begin
            r_pipe_id[k]  <= '0;
            r_pipe_tag[k] <= '0;
         end
      end else begin
         r_pipe_vld[0] <= w_grant;
         r_pipe_id[0]  <= w_winner;
         r_pipe_tag[0] <= w_req_sel[c_req_w-1:ADDR_W];
         for (int k = 1; k < c_depth; k++) begin
            r_pipe_vld[k] <= r_pipe_vld[k-1];
            r_pipe_id[k]  <= r_pipe_id[k-1];
            r_pipe_tag[k] <= r_pipe_tag[k-1];
         end
      end
   end

   // Response register: one-hot valid, payload held while no response
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_rsp_vld  <= '0;
         r_rsp_data <= '0;
      end else begin
         r_rsp_vld <= '0;
         if (r_pipe_vld[MEM_LATENCY]) begin
            r_rsp_vld[r_pipe_id[MEM_LATENCY]] <= 1'b1;
            r_rsp_data <= {r_pipe_tag[MEM_LATENCY], mem_rdata_in};
         end
      end
   end

   assign mem_en_out    = r_mem_en;
   assign mem_addr_out  = r_mem_addr;
   assign rsp_valid_out = r_rsp_vld;
   assign rsp_out       = r_rsp_data;
   assign drained_out   = (r_state == S_DRAINED);
   assign idle_out      = w_pipe_empty;

endmodule
`default_nettype wire

// File: tb/tb_graph_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_graph_mem_arbiter
// Purpose  : Self-checking bench for graph_mem_arbiter. dut1 uses defaults
//            (2 requesters, latency 2); dut2 uses 3 requesters, latency 1.
//            BRAM model returns addr ^ 0x16. A scoreboard per DUT records
//            each grant and checks the routed response and its latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_graph_mem_arbiter;

   typedef struct {
      int          id;
      logic [3:0]  tag;
      logic [31:0] data;
      int          cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_err = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // dut1 signals
   logic [1:0]  v1, rdy1, rv1;
   logic [71:0] rq1;
   logic        en1, drain1, drained1, idle1;
   logic [31:0] addr1, rdata1;
   logic [35:0] rout1;
   // dut2 signals
   logic [2:0]   v2, rdy2, rv2;
   logic [107:0] rq2;
   logic         en2, drain2, drained2, idle2;
   logic [31:0]  addr2, rdata2;
   logic [35:0]  rout2;

   graph_mem_arbiter dut1 (
      .clk_in(clk), .rst_in(rst), .req_valid_in(v1), .req_in(rq1),
      .req_ready_out(rdy1), .mem_en_out(en1), .mem_addr_out(addr1),
      .mem_rdata_in(rdata1), .rsp_valid_out(rv1), .rsp_out(rout1),
      .drain_in(drain1), .drained_out(drained1), .idle_out(idle1)
   );

   graph_mem_arbiter #(.NUM_REQ(3), .MEM_LATENCY(1)) dut2 (
      .clk_in(clk), .rst_in(rst), .req_valid_in(v2), .req_in(rq2),
      .req_ready_out(rdy2), .mem_en_out(en2), .mem_addr_out(addr2),
      .mem_rdata_in(rdata2), .rsp_valid_out(rv2), .rsp_out(rout2),
      .drain_in(drain2), .drained_out(drained2), .idle_out(idle2)
   );

   // BRAM models: data = addr ^ 0x16, delivered MEM_LATENCY cycles after enable
   logic [31:0] bm1 [2];
   logic [31:0] bm2;
   always @(posedge clk) begin
      bm1[0] <= en1 ? (addr1 ^ 32'h16) : 32'hDEAD_BEEF;
      bm1[1] <= bm1[0];
      bm2    <= en2 ? (addr2 ^ 32'h16) : 32'hDEAD_BEEF;
   end
   assign rdata1 = bm1[1];
   assign rdata2 = bm2;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h exp %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // dut1 scoreboard/monitor
   exp_t        q1[$];
   exp_t        e1;
   logic        xen1 = 1'b0;
   logic [31:0] xaddr1 = '0;
   int          nrsp1 = 0;
   int          last_rsp1 = 0;
   always @(negedge clk) begin
      if (rst) begin
         q1.delete();
         xen1 = 1'b0;
      end else begin
         chk("m1_en", en1, xen1);
         if (xen1) chk("m1_addr", addr1, xaddr1);
         if (rv1 != 0) begin
            if (q1.size() == 0) chk("r1_unexp", rv1, 0);
            else begin
               e1 = q1.pop_front();
               chk("r1_id", rv1, 64'(1) << e1.id);
               chk("r1_out", rout1, {e1.tag, e1.data});
               chk("r1_lat", cyc, e1.cyc + 4);
               nrsp1++;
               last_rsp1 = cyc;
            end
         end
         chk("r1_sub", rdy1 & ~v1, 0);
         xen1 = 1'b0;
         for (int i = 0; i < 2; i++) begin
            if (rdy1[i] && v1[i]) begin
               q1.push_back('{i, rq1[i*36+32 +: 4], rq1[i*36 +: 32] ^ 32'h16, cyc});
               xen1   = 1'b1;
               xaddr1 = rq1[i*36 +: 32];
            end
         end
      end
   end

   // dut2 scoreboard/monitor
   exp_t        q2[$];
   exp_t        e2;
   logic        xen2 = 1'b0;
   logic [31:0] xaddr2 = '0;
   int          nrsp2 = 0;
   always @(negedge clk) begin
      if (rst) begin
         q2.delete();
         xen2 = 1'b0;
      end else begin
         chk("m2_en", en2, xen2);
         if (xen2) chk("m2_addr", addr2, xaddr2);
         if (rv2 != 0) begin
            if (q2.size() == 0) chk("r2_unexp", rv2, 0);
            else begin
               e2 = q2.pop_front();
               chk("r2_id", rv2, 64'(1) << e2.id);
               chk("r2_out", rout2, {e2.tag, e2.data});
               chk("r2_lat", cyc, e2.cyc + 3);
               nrsp2++;
            end
         end
         chk("r2_sub", rdy2 & ~v2, 0);
         xen2 = 1'b0;
         for (int i = 0; i < 3; i++) begin
            if (rdy2[i] && v2[i]) begin
               q2.push_back('{i, rq2[i*36+32 +: 4], rq2[i*36 +: 32] ^ 32'h16, cyc});
               xen2   = 1'b1;
               xaddr2 = rq2[i*36 +: 32];
            end
         end
      end
   end

   task automatic wait_idle(input int which);
      bit done = 0;
      for (int n = 0; n < 30 && !done; n++) begin
         @(negedge clk);
         if (which == 1) done = idle1 && (q1.size() == 0);
         else            done = idle2 && (q2.size() == 0);
      end
      chk("idle_timeout", done, 1);
   endtask

   task automatic reset_vals(input string tag);
      chk({tag, "_en"}, en1, 0);
      chk({tag, "_addr"}, addr1, 0);
      chk({tag, "_rv"}, rv1, 0);
      chk({tag, "_rout"}, rout1, 0);
      chk({tag, "_drained"}, drained1, 0);
      chk({tag, "_idle"}, idle1, 1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int n0;
      bit done;
      rst = 1'b1; v1 = '0; rq1 = '0; drain1 = 1'b0;
      v2 = '0; rq2 = '0; drain2 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset_vals("rst");
      rst = 1'b0;

      // T1: single request {3,0x10}, expect {3,6} four cycles later
      @(posedge clk); #1;
      v1 = 2'b01; rq1[35:0] = {4'd3, 32'h10};
      @(negedge clk); chk("t1_rdy", rdy1, 2'b01);
      @(posedge clk); #1; v1 = '0;
      @(negedge clk);
      chk("t1_en", en1, 1);
      chk("t1_addr", addr1, 32'h10);
      repeat (3) @(negedge clk);
      chk("t1_rv", rv1, 2'b01);
      chk("t1_rsp", rout1, {4'd3, 32'd6});
      wait_idle(1);

      // T2: both valid 8 cycles; ptr is 1 after T1, so 1,0,1,0...
      n0 = nrsp1;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         v1 = 2'b11;
         rq1[35:0]  = {4'(i),     32'h100 + 32'(i)};
         rq1[71:36] = {4'(i + 8), 32'h200 + 32'(i)};
         @(negedge clk); chk("t2_rdy", rdy1, (i % 2 == 0) ? 2'b10 : 2'b01);
      end
      @(posedge clk); #1; v1 = '0;
      wait_idle(1);
      chk("t2_cnt", nrsp1 - n0, 8);

      // T3: only requester 1 valid, 4 back-to-back grants
      n0 = nrsp1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         v1 = 2'b10;
         rq1[71:36] = {4'(i + 4), 32'h400 + 32'(i)};
         @(negedge clk); chk("t3_rdy", rdy1, 2'b10);
      end
      @(posedge clk); #1; v1 = '0;
      wait_idle(1);
      chk("t3_cnt", nrsp1 - n0, 4);

      // T4: three reads in flight, then drain while requester 0 stays valid
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         v1 = 2'b01;
         rq1[35:0] = {4'(i + 1), 32'h300 + 32'(i)};
         @(negedge clk); chk("t4_rdy", rdy1, 2'b01);
      end
      @(posedge clk); #1; drain1 = 1'b1;
      @(negedge clk); chk("t4_sup", rdy1, 0);
      done = 0;
      for (int n = 0; n < 20 && !done; n++) begin
         @(negedge clk);
         chk("t4_nogrant", rdy1, 0);
         done = drained1;
      end
      chk("t4_drained", drained1, 1);
      chk("t4_when", cyc, last_rsp1 + 1);
      chk("t4_idle", idle1, 1);
      @(posedge clk); #1; drain1 = 1'b0;
      @(negedge clk);
      chk("t4_still", rdy1, 0);
      chk("t4_drained2", drained1, 1);
      @(negedge clk);
      chk("t4_resume", rdy1, 2'b01);
      chk("t4_undrained", drained1, 0);
      @(posedge clk); #1; v1 = '0;
      wait_idle(1);

      // T5: async reset with two reads in flight
      n0 = nrsp1;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         v1 = 2'b01;
         rq1[35:0] = {4'(i + 9), 32'h500 + 32'(i)};
      end
      @(posedge clk); #1; v1 = '0;
      @(negedge clk); chk("t5_busy", idle1, 0);
      #2; rst = 1'b1;
      #1; reset_vals("t5");
      @(posedge clk); @(posedge clk); #3; rst = 1'b0;
      for (int n = 0; n < 8; n++) begin
         @(negedge clk);
         chk("t5_norsp", rv1, 0);
      end
      chk("t5_cnt", nrsp1 - n0, 0);
      chk("t5_idle", idle1, 1);

      // T6: dut2, 3 requesters all valid, latency 1: rotation 0,1,2,0,1,2
      n0 = nrsp2;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         v2 = 3'b111;
         for (int r = 0; r < 3; r++) begin
            rq2[r*36 +: 36] = {4'(r * 5 + i), 32'h600 + 32'(r * 16 + i)};
         end
         @(negedge clk); chk("t6_rdy", rdy2, 3'b001 << (i % 3));
      end
      @(posedge clk); #1; v2 = '0;
      wait_idle(2);
      chk("t6_cnt", nrsp2 - n0, 6);

      chk("q1_empty", q1.size(), 0);
      chk("q2_empty", q2.size(), 0);
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
`default_nettype wire
